// File: rtl/mem_if_unit_if.sv
// Bus and mode-strobe bundle between the control FSM (master) and mem_if_unit (slave).
interface mem_if_unit_if;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_drive;
  logic [1:0]  mar_bus_mode;
  logic [1:0]  mdr_bus_mode;
  logic [1:0]  mdr_mem_mode;
  logic [1:0]  mem_mode;
  logic        mem_busy;
  logic [15:0] mar_q;
  logic [15:0] mdr_q;
  logic        err_conflict;
  logic        err_illegal;

  modport master (
    output bus_in, mar_bus_mode, mdr_bus_mode, mdr_mem_mode, mem_mode,
    input  bus_out, bus_drive, mem_busy, mar_q, mdr_q, err_conflict, err_illegal
  );

  modport slave (
    input  bus_in, mar_bus_mode, mdr_bus_mode, mdr_mem_mode, mem_mode,
    output bus_out, bus_drive, mem_busy, mar_q, mdr_q, err_conflict, err_illegal
  );
endinterface

// File: rtl/mem_if_unit.sv
// MAR/MDR + word memory stage; reads land in MDR READ_LAT cycles after acceptance, mem_busy drops requests meanwhile.
// Define MEM_IF_BOUNDS_EN to reject MAR values >= MEM_DEPTH instead of wrapping.
module mem_if_unit #(
  parameter int MEM_DEPTH = 4096,
  parameter int READ_LAT  = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_if_unit_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic {S_IDLE, S_READ_WAIT} state_t;

  state_t        state;
  logic [15:0]   mar;
  logic [15:0]   mdr;
  logic          busy;
  logic [2:0]    cnt;
  logic [AW-1:0] rd_addr;
  logic          rd_oob;
  logic          err_conflict_r;
  logic          err_illegal_r;

  logic [15:0]   mem [MEM_DEPTH];

  logic [AW-1:0] idx;
  logic          wr_req;
  logic          rd_req;
  logic          combo_bad;
  logic          mode3;
  logic          oob_now;
  logic          rd_accept;
  logic          rd_done;
  logic          wr_ok;
  logic          bus_clash;

  assign idx       = mar[AW-1:0];
  assign wr_req    = (bus.mem_mode == 2'd1) && (bus.mdr_mem_mode == 2'd2);
  assign rd_req    = (bus.mem_mode == 2'd2) && (bus.mdr_mem_mode == 2'd1);
  assign combo_bad = ((bus.mem_mode != 2'd0) || (bus.mdr_mem_mode != 2'd0)) && !wr_req && !rd_req;
  assign mode3     = (bus.mar_bus_mode == 2'd3) || (bus.mdr_bus_mode == 2'd3);

`ifdef MEM_IF_BOUNDS_EN
  assign oob_now = ({1'b0, mar} >= 17'(MEM_DEPTH));
`else
  assign oob_now = 1'b0;
`endif

  assign rd_accept = (state == S_IDLE) && rd_req;
  assign wr_ok     = (state == S_IDLE) && wr_req && !oob_now;
  // A read "completes" either at the accepting edge (single-cycle latency) or on the last wait edge.
  assign rd_done   = (rd_accept && (READ_LAT == 1)) || ((state == S_READ_WAIT) && (cnt == 3'd1));
  assign bus_clash = (bus.mar_bus_mode == 2'd2) && (bus.mdr_bus_mode == 2'd2);

  always_comb begin
    bus.bus_out   = 16'h0000;
    bus.bus_drive = 1'b0;
    if (bus.mdr_bus_mode == 2'd2) begin
      bus.bus_out   = mdr;
      bus.bus_drive = 1'b1;
    end else if (bus.mar_bus_mode == 2'd2) begin
      bus.bus_out   = mar;
      bus.bus_drive = 1'b1;
    end
  end

  // Array is never reset; writes are blocked on reset edges so a reset cycle has no side effects.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok)
      mem[idx] <= mdr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      mar            <= 16'h0000;
      mdr            <= 16'h0000;
      busy           <= 1'b0;
      cnt            <= 3'd0;
      rd_addr        <= '0;
      rd_oob         <= 1'b0;
      err_conflict_r <= 1'b0;
      err_illegal_r  <= 1'b0;
    end else begin
      err_conflict_r <= bus_clash || (rd_done && (bus.mdr_bus_mode == 2'd1));
      err_illegal_r  <= mode3 || combo_bad || (oob_now && (state == S_IDLE) && (wr_req || rd_req));

      if (bus.mar_bus_mode == 2'd1)
        mar <= bus.bus_in;
      if (bus.mdr_bus_mode == 2'd1)
        mdr <= bus.bus_in;

      // Memory data is assigned after the bus load so it wins on a shared edge.
      case (state)
        S_IDLE: begin
          if (rd_accept) begin
            if (READ_LAT == 1) begin
              mdr <= oob_now ? 16'h0000 : mem[idx];
            end else begin
              rd_addr <= idx;
              rd_oob  <= oob_now;
              cnt     <= 3'(READ_LAT - 1);
              busy    <= 1'b1;
              state   <= S_READ_WAIT;
            end
          end
        end
        S_READ_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            mdr   <= rd_oob ? 16'h0000 : mem[rd_addr];
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_busy     = busy;
  assign bus.mar_q        = mar;
  assign bus.mdr_q        = mdr;
  assign bus.err_conflict = err_conflict_r;
  assign bus.err_illegal  = err_illegal_r;

endmodule
